sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single-port 512x32 custom SRAM between three requesters: core0 instruction fetch (IF), core0 data port (DM) and the Wishbone host loader (WB).
- Sits in the user project between core0 and custom_sram, and between the Wishbone slave and custom_sram.
- Round-robin arbitration with one grant per cycle.
- Fixed 1-cycle SRAM read latency, returned on a per-requester rvalid.

Parameters:
- ADDR_W, 9, SRAM word-address width (512 words).
- DATA_W, 32, SRAM data width; the byte mask is DATA_W/8 bits.

Ports:
- wb_clk_i  in  1  clock, rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- if_req  in  1  IF read request
- if_addr  in  ADDR_W  IF word address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- dm_req  in  1  DM request
- dm_we  in  1  DM write (1) / read (0)
- dm_addr  in  ADDR_W  DM word address
- dm_wdata  in  DATA_W  DM write data
- dm_wmask  in  DATA_W/8  DM byte enables
- dm_gnt  out  1  DM accepted
- dm_rvalid  out  1  DM read data valid
- wb_req, wb_we, wb_addr, wb_wdata, wb_wmask, wb_gnt, wb_rvalid: same widths and meanings as the dm_* ports, for the Wishbone loader
- rdata  out  DATA_W  shared read data; valid only with an rvalid
- sram_csb  out  1  SRAM chip select, active-low
- sram_web  out  1  SRAM write enable, active-low
- sram_wmask  out  DATA_W/8  SRAM byte mask
- sram_addr  out  ADDR_W  SRAM address
- sram_din  out  DATA_W  SRAM write data
- sram_dout  in  DATA_W  SRAM read data, valid one cycle after a read command
- perf_if_cnt, perf_dm_cnt, perf_wb_cnt, perf_conflict_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (while wb_rst_i=1, sampled at the clock edge):
  - rr_ptr=IF; all rvalid=0; counters=0.
  - All gnt=0 combinationally while wb_rst_i=1.
  - SRAM idle values driven.
  - A read issued in the cycle reset asserts produces no rvalid.
- SRAM idle values: sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, sram_wmask=0.
- Priority order each cycle: starts at rr_ptr, then cycles IF->DM->WB->IF. The first requester with req=1 wins.
- Grant is combinational in the same cycle T:
  - winner's gnt=1, others 0.
  - SRAM is driven from the winner in cycle T: csb=0; web=~we; addr; din and wmask from the winner.
  - IF is always a read: web=1, wmask=0.
- rr_ptr update:
  - After granting requester k, rr_ptr <= successor of k.
  - If no req, rr_ptr is unchanged and SRAM stays idle.
- Read response:
  - winner's rvalid=1 in cycle T+1 (registered one-hot of the read winner).
  - rdata = sram_dout in T+1, passed through combinationally.
  - A write produces no rvalid.
  - rdata is 0 whenever no rvalid is set.
- Requester contract: req, we, addr, wdata and wmask are held stable until gnt. The requester may drop req after gnt, or keep it asserted for back-to-back requests.
- Throughput:
  - One access per cycle.
  - A sole requester holding req is granted every cycle; a read every cycle gives rvalid every cycle.
- Starvation bound: with all three requesting continuously, each requester is granted at least once every 3 cycles.
- Simultaneous read and write to the same address by different requesters: serialized by arbitration. A read granted after a write returns the new data.
- The arbiter never writes sram_* while wb_rst_i=1.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined:
  - perf_if_cnt, perf_dm_cnt and perf_wb_cnt increment on each cycle their requester receives gnt.
  - perf_conflict_cnt increments on each cycle where two or more req are high (with gnt not gated by reset).
  - Counters are 32-bit, wrap on overflow, and are cleared by wb_rst_i.
- Undefined: the counter logic is absent and all four perf ports are tied to 0. Port list is unchanged.

Test Plan:
- Reset, then IF only reads addr 0x005 with sram_dout=0xDEADBEEF:
  - if_gnt=1 in T; sram_csb=0, sram_web=1, sram_addr=0x005.
  - T+1: if_rvalid=1, rdata=0xDEADBEEF; dm_rvalid=wb_rvalid=0.
- WB writes 0x12345678 to 0x1FF with mask 0xF, then DM reads 0x1FF:
  - SRAM sees the write, then the read on consecutive cycles.
  - dm_rvalid=1 with rdata=0x12345678; no wb_rvalid.
- IF, DM and WB all hold req for 6 cycles from reset:
  - grant sequence IF, DM, WB, IF, DM, WB.
  - With PERF_EN: each per-requester count=2, perf_conflict_cnt=6.
- Only DM and WB request, with rr_ptr=WB:
  - WB is granted first, then DM; rr_ptr ends at WB.
- Assert wb_rst_i in the cycle a DM read is granted (gnt forced 0):
  - no dm_rvalid next cycle; SRAM idle during reset.
  - First post-reset grant goes to IF when all request.
- Byte write from DM with wmask=0x4, data 0x00AB0000:
  - sram_wmask=0x4, sram_web=0, sram_din=0x00AB0000.
  - No rvalid; perf_dm_cnt=1 with PERF_EN, 0 without.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side bus bundle for sram_port_arbiter.
// The arbiter connects through the slave modport; requesters and the SRAM macro drive the master side.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_wmask;
    logic                  dm_gnt;
    logic                  dm_rvalid;

    logic                  wb_req;
    logic                  wb_we;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_wdata;
    logic [DATA_W/8-1:0]   wb_wmask;
    logic                  wb_gnt;
    logic                  wb_rvalid;

    logic [DATA_W-1:0]     rdata;

    logic                  sram_csb;
    logic                  sram_web;
    logic [DATA_W/8-1:0]   sram_wmask;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_din;
    logic [DATA_W-1:0]     sram_dout;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
        input  wb_req, wb_we, wb_addr, wb_wdata, wb_wmask,
        input  sram_dout,
        output if_gnt, if_rvalid, dm_gnt, dm_rvalid, wb_gnt, wb_rvalid, rdata,
        output sram_csb, sram_web, sram_wmask, sram_addr, sram_din
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
        output wb_req, wb_we, wb_addr, wb_wdata, wb_wmask,
        output sram_dout,
        input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, wb_gnt, wb_rvalid, rdata,
        input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency SRAM between core0 IF, core0 DM and the Wishbone loader.
// Optional performance counters are built when SRAM_ARB_PERF_EN is defined; otherwise the perf ports read 0.
module sram_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    sram_port_arbiter_if.slave  bus,
    output logic [31:0]         perf_if_cnt,
    output logic [31:0]         perf_dm_cnt,
    output logic [31:0]         perf_wb_cnt,
    output logic [31:0]         perf_conflict_cnt
);
    localparam int                 MASK_W    = DATA_W / 8;
    localparam logic [ADDR_W-1:0]  IDLE_ADDR = '0;
    localparam logic [MASK_W-1:0]  NO_MASK   = '0;

    typedef enum logic [1:0] {
        PTR_IF = 2'd0,
        PTR_DM = 2'd1,
        PTR_WB = 2'd2
    } ptr_t;

    ptr_t       rr_ptr;
    ptr_t       rr_ptr_next;
    logic [2:0] req;        // {wb, dm, if}
    logic [2:0] gnt;
    logic [2:0] rd_gnt;
    logic [2:0] rvalid_q;

    // Requests are masked during reset so no grant or SRAM command can escape
    assign req = wb_rst_i ? '0 : {bus.wb_req, bus.dm_req, bus.if_req};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rr_ptr <= PTR_IF;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    always_comb begin
        gnt         = '0;
        rr_ptr_next = rr_ptr;
        case (rr_ptr)
            PTR_IF: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
            PTR_DM: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            PTR_WB: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: gnt = '0;
        endcase
        if      (gnt[0]) rr_ptr_next = PTR_DM;
        else if (gnt[1]) rr_ptr_next = PTR_WB;
        else if (gnt[2]) rr_ptr_next = PTR_IF;
    end

    always_comb begin
        bus.sram_csb   = 1'b1;
        bus.sram_web   = 1'b1;
        bus.sram_addr  = IDLE_ADDR;
        bus.sram_din   = '0;
        bus.sram_wmask = NO_MASK;
        if (gnt[0]) begin
            bus.sram_csb   = 1'b0;
            bus.sram_addr  = bus.if_addr;
        end else if (gnt[1]) begin
            bus.sram_csb   = 1'b0;
            bus.sram_web   = ~bus.dm_we;
            bus.sram_addr  = bus.dm_addr;
            bus.sram_din   = bus.dm_wdata;
            bus.sram_wmask = bus.dm_wmask;
        end else if (gnt[2]) begin
            bus.sram_csb   = 1'b0;
            bus.sram_web   = ~bus.wb_we;
            bus.sram_addr  = bus.wb_addr;
            bus.sram_din   = bus.wb_wdata;
            bus.sram_wmask = bus.wb_wmask;
        end
    end

    assign bus.if_gnt = gnt[0];
    assign bus.dm_gnt = gnt[1];
    assign bus.wb_gnt = gnt[2];

    // Only reads earn a response slot; IF never writes
    assign rd_gnt = gnt & {~bus.wb_we, ~bus.dm_we, 1'b1};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rd_gnt;
        end
    end

    assign bus.if_rvalid = rvalid_q[0];
    assign bus.dm_rvalid = rvalid_q[1];
    assign bus.wb_rvalid = rvalid_q[2];
    assign bus.rdata     = (|rvalid_q) ? bus.sram_dout : '0;

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] if_cnt;
    logic [31:0] dm_cnt;
    logic [31:0] wb_cnt;
    logic [31:0] conflict_cnt;
    logic        conflict;

    assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            if_cnt       <= '0;
            dm_cnt       <= '0;
            wb_cnt       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt[0])   if_cnt       <= if_cnt + 32'd1;
            if (gnt[1])   dm_cnt       <= dm_cnt + 32'd1;
            if (gnt[2])   wb_cnt       <= wb_cnt + 32'd1;
            if (conflict) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    assign perf_if_cnt       = if_cnt;
    assign perf_dm_cnt       = dm_cnt;
    assign perf_wb_cnt       = wb_cnt;
    assign perf_conflict_cnt = conflict_cnt;
`else
    assign perf_if_cnt       = '0;
    assign perf_dm_cnt       = '0;
    assign perf_wb_cnt       = '0;
    assign perf_conflict_cnt = '0;
`endif

endmodule
